// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states, timeout limit
// and small decode helpers.
package mem_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // BUSY cycles without an ack before the access is abandoned
   localparam logic [7:0] WAIT_LIMIT = 8'd255;

   // Unused codes 9-15 fold onto NONE so they behave as plain pass-through
   function automatic mem_op_e decode_op(input logic [3:0] code);
      mem_op_e op;
      op = OP_NONE;
      if (code <= 4'd8) op = mem_op_e'(code);
      return op;
   endfunction

   function automatic logic op_is_load(input mem_op_e op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: bad = a[0];
         OP_LW, OP_SW:         bad = (a != 2'b00);
         default:              bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a memory read word.
module load_align
   import mem_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed lane, then extend according to the load flavour
   always_comb begin
      byte_lane = rdata[{addr, 3'b000} +: 8];
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
      case (decode_op(op))
         OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  result = {24'd0, byte_lane};
         OP_LH:   result = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  result = {16'd0, half_lane};
         OP_LW:   result = rdata;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes non-memory results straight through and runs
// loads/stores over a single-request data-memory port with ack timeout.
module mem_access
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   output logic        stallReq,
   input  logic [4:0]  exWriteNum,
   input  logic        exWriteReg,
   input  logic [31:0] exWriteData,
   input  logic [3:0]  exMemOp,
   input  logic [31:0] exMemAddr,
   input  logic [31:0] exStoreData,
   output logic [4:0]  MemWriteNum,
   output logic        MemWriteReg,
   output logic [31:0] MemWriteData,
   output logic        dmReq,
   output logic        dmWe,
   output logic [31:0] dmAddr,
   output logic [3:0]  dmBe,
   output logic [31:0] dmWdata,
   input  logic [31:0] dmRdata,
   input  logic        dmAck,
   output logic        misalign,
   output logic        busErr
);

   mem_state_e  state_reg;
   logic [3:0]  op_reg;
   logic [31:0] addr_reg;
   logic        we_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [4:0]  num_reg;
   logic        wreg_reg;
   logic [31:0] hold_reg;
   logic [7:0]  wait_cnt_reg;
   logic        misalign_reg;
   logic        buserr_reg;

   mem_op_e     op_in;
   logic        in_load;
   logic        in_mem;
   logic        in_mis;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_result;

   // Only the MEM-stage hold bit matters here
   logic        stall_unused;
   assign stall_unused = ^{stall[5], stall[3:0]};

   // Decode the incoming op and precompute the store byte lanes
   always_comb begin
      op_in      = decode_op(exMemOp);
      in_load    = op_is_load(op_in);
      in_mem     = in_load | op_is_store(op_in);
      in_mis     = op_misaligned(op_in, exMemAddr[1:0]);
      be_next    = 4'b0000;
      wdata_next = 32'd0;
      case (op_in)
         OP_SB: begin
            be_next    = 4'b0001 << exMemAddr[1:0];
            wdata_next = {4{exStoreData[7:0]}};
         end
         OP_SH: begin
            be_next    = exMemAddr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{exStoreData[15:0]}};
         end
         OP_SW: begin
            be_next    = 4'b1111;
            wdata_next = exStoreData;
         end
         default: ;
      endcase
   end

   load_align u_load_align (
      .op     (op_reg),
      .addr   (addr_reg[1:0]),
      .rdata  (dmRdata),
      .result (load_result)
   );

   // Access FSM with registered request copies, hold data and fault pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         op_reg       <= 4'd0;
         addr_reg     <= 32'd0;
         we_reg       <= 1'b0;
         be_reg       <= 4'd0;
         wdata_reg    <= 32'd0;
         num_reg      <= 5'd0;
         wreg_reg     <= 1'b0;
         hold_reg     <= 32'd0;
         wait_cnt_reg <= 8'd0;
         misalign_reg <= 1'b0;
         buserr_reg   <= 1'b0;
      end else begin
         misalign_reg <= 1'b0;
         buserr_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (in_mem && in_mis) begin
                  misalign_reg <= 1'b1;
               end else if (in_mem) begin
                  op_reg       <= op_in;
                  addr_reg     <= exMemAddr;
                  we_reg       <= ~in_load;
                  be_reg       <= in_load ? 4'b1111 : be_next;
                  wdata_reg    <= wdata_next;
                  num_reg      <= exWriteNum;
                  wreg_reg     <= exWriteReg & in_load;
                  wait_cnt_reg <= 8'd0;
                  state_reg    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (dmAck) begin
                  hold_reg  <= we_reg ? 32'd0 : load_result;
                  state_reg <= ST_DONE;
               end else if (wait_cnt_reg == WAIT_LIMIT - 8'd1) begin
                  wait_cnt_reg <= WAIT_LIMIT;
                  hold_reg     <= 32'd0;
                  buserr_reg   <= 1'b1;
                  state_reg    <= ST_DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            ST_DONE: begin
               if (!stall[4]) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Writeback and stall outputs: pass-through in IDLE, held result in DONE
   always_comb begin
      stallReq     = 1'b0;
      MemWriteNum  = num_reg;
      MemWriteReg  = 1'b0;
      MemWriteData = hold_reg;
      if (!rst) begin
         case (state_reg)
            ST_IDLE: begin
               MemWriteNum  = exWriteNum;
               MemWriteData = exWriteData;
               MemWriteReg  = exWriteReg & ~in_mem;
               stallReq     = in_mem & ~in_mis;
            end
            ST_BUSY: stallReq = 1'b1;
            ST_DONE: MemWriteReg = wreg_reg;
            default: ;
         endcase
      end
   end

   assign dmReq    = (state_reg == ST_BUSY);
   assign dmWe     = we_reg;
   assign dmAddr   = {addr_reg[31:2], 2'b00};
   assign dmBe     = be_reg;
   assign dmWdata  = wdata_reg;
   assign misalign = misalign_reg;
   assign busErr   = buserr_reg;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access with a word-array memory model.
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        stallReq;
   logic [4:0]  exWriteNum;
   logic        exWriteReg;
   logic [31:0] exWriteData;
   logic [3:0]  exMemOp;
   logic [31:0] exMemAddr;
   logic [31:0] exStoreData;
   logic [4:0]  MemWriteNum;
   logic        MemWriteReg;
   logic [31:0] MemWriteData;
   logic        dmReq;
   logic        dmWe;
   logic [31:0] dmAddr;
   logic [3:0]  dmBe;
   logic [31:0] dmWdata;
   logic [31:0] dmRdata;
   logic        dmAck;
   logic        misalign;
   logic        busErr;

   int total = 0;
   int bad = 0;
   logic [31:0] mem [0:15];

   mem_access dut (
      .clk(clk), .rst(rst), .stall(stall), .stallReq(stallReq),
      .exWriteNum(exWriteNum), .exWriteReg(exWriteReg), .exWriteData(exWriteData),
      .exMemOp(exMemOp), .exMemAddr(exMemAddr), .exStoreData(exStoreData),
      .MemWriteNum(MemWriteNum), .MemWriteReg(MemWriteReg), .MemWriteData(MemWriteData),
      .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmBe(dmBe), .dmWdata(dmWdata),
      .dmRdata(dmRdata), .dmAck(dmAck), .misalign(misalign), .busErr(busErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- reference model, straight from the op-code rules ----
   function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> ((addr % 4) * 8)) & 32'hFF;
      h = (word >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
      case (op)
         1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         2: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3: return word;
         4: return b;
         5: return h;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input int op, input logic [31:0] addr);
      case (op)
         6: return 4'(1 << (addr % 4));
         7: return 4'(3 << (addr & 2));
         8: return 4'hF;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input int op, input logic [31:0] sdata);
      case (op)
         6: return (sdata & 32'hFF) * 32'h0101_0101;
         7: return (sdata & 32'hFFFF) * 32'h0001_0001;
         default: return sdata;
      endcase
   endfunction

   function automatic bit model_misaligned(input int op, input logic [31:0] addr);
      if ((op == 2 || op == 5 || op == 7) && (addr % 2 != 0)) return 1;
      if ((op == 3 || op == 8) && (addr % 4 != 0)) return 1;
      return 0;
   endfunction

   task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] num, input logic wreg, input logic [31:0] wdata);
      exMemOp = op; exMemAddr = addr; exStoreData = sdata;
      exWriteNum = num; exWriteReg = wreg; exWriteData = wdata;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; stall = 6'd0; dmAck = 1'b0; dmRdata = 32'd0;
      set_ex(4'd3, 32'h100, 32'd0, 5'd9, 1'b1, 32'h5555);
      #2;
      total++; if (MemWriteReg !== 1'b0) begin bad++; $display("FAIL reset_memwritereg got=%b want=0", MemWriteReg); end
      total++; if (stallReq !== 1'b0) begin bad++; $display("FAIL reset_stallreq got=%b want=0", stallReq); end
      total++; if (dmReq !== 1'b0) begin bad++; $display("FAIL reset_dmreq got=%b want=0", dmReq); end
      total++; if ({misalign, busErr} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {misalign, busErr}); end
      total++; if (MemWriteData !== 32'd0) begin bad++; $display("FAIL reset_hold got=%h want=0", MemWriteData); end
      set_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      $display("txn reset released");
   endtask

   task automatic test_none_pass;
      set_ex(4'd0, 32'h104, 32'd0, 5'd5, 1'b1, 32'h1234);
      #1;
      total++; if (MemWriteData !== 32'h1234) begin bad++; $display("FAIL none_data got=%h want=1234", MemWriteData); end
      total++; if (MemWriteNum !== 5'd5) begin bad++; $display("FAIL none_num got=%0d want=5", MemWriteNum); end
      total++; if (MemWriteReg !== 1'b1) begin bad++; $display("FAIL none_wreg got=%b want=1", MemWriteReg); end
      total++; if (stallReq !== 1'b0) begin bad++; $display("FAIL none_stall got=%b want=0", stallReq); end
      tick();
      set_ex(4'd13, 32'h101, 32'd0, 5'd17, 1'b1, 32'hDEAD_0013);
      #1;
      total++; if ({stallReq, MemWriteReg, MemWriteData} !== {1'b0, 1'b1, 32'hDEAD_0013}) begin bad++; $display("FAIL none_code13 got=%b/%b/%h want=0/1/dead0013", stallReq, MemWriteReg, MemWriteData); end
      tick();
      total++; if ({dmReq, misalign} !== 2'b00) begin bad++; $display("FAIL none_noreq got=%b want=00", {dmReq, misalign}); end
      $display("txn none pass-through");
   endtask

   task automatic test_lb_example;
      set_ex(4'd1, 32'h103, 32'd0, 5'd3, 1'b1, 32'h0BAD);
      #1;
      total++; if (stallReq !== 1'b1) begin bad++; $display("FAIL lb_stall_c1 got=%b want=1", stallReq); end
      tick();
      total++; if ({dmReq, stallReq, dmWe} !== 3'b110) begin bad++; $display("FAIL lb_busy got=%b want=110", {dmReq, stallReq, dmWe}); end
      total++; if (dmAddr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h want=100", dmAddr); end
      dmAck = 1'b1; dmRdata = 32'h80FF_FF00;
      tick();
      dmAck = 1'b0; dmRdata = 32'h0;
      total++; if (stallReq !== 1'b0) begin bad++; $display("FAIL lb_stall_c3 got=%b want=0", stallReq); end
      total++; if (MemWriteData !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", MemWriteData); end
      total++; if ({MemWriteReg, MemWriteNum} !== {1'b1, 5'd3}) begin bad++; $display("FAIL lb_dest got=%b/%0d want=1/3", MemWriteReg, MemWriteNum); end
      total++; if (dmReq !== 1'b0) begin bad++; $display("FAIL lb_done_req got=%b want=0", dmReq); end
      tick();
      $display("txn LB 0x103 -> %h", 32'hFFFF_FF80);
   endtask

   task automatic test_sh_example;
      set_ex(4'd7, 32'h102, 32'hAAAA_BEEF, 5'd4, 1'b1, 32'd0);
      tick();
      total++; if (dmBe !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", dmBe); end
      total++; if (dmWdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got=%h want=beefbeef", dmWdata); end
      total++; if ({dmAddr, dmWe, dmReq} !== {32'h100, 1'b1, 1'b1}) begin bad++; $display("FAIL sh_req got=%h/%b/%b want=100/1/1", dmAddr, dmWe, dmReq); end
      dmAck = 1'b1;
      tick();
      dmAck = 1'b0;
      total++; if (MemWriteReg !== 1'b0) begin bad++; $display("FAIL sh_wreg got=%b want=0", MemWriteReg); end
      tick();
      $display("txn SH 0x102 data=aaaabeef");
   endtask

   task automatic test_misalign;
      set_ex(4'd3, 32'h101, 32'd0, 5'd6, 1'b1, 32'h77);
      #1;
      total++; if ({stallReq, MemWriteReg, dmReq} !== 3'b000) begin bad++; $display("FAIL mis_comb got=%b want=000", {stallReq, MemWriteReg, dmReq}); end
      tick();
      total++; if ({misalign, dmReq} !== 2'b10) begin bad++; $display("FAIL mis_pulse got=%b want=10", {misalign, dmReq}); end
      set_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      tick();
      total++; if ({misalign, dmReq} !== 2'b00) begin bad++; $display("FAIL mis_end got=%b want=00", {misalign, dmReq}); end
      $display("txn LW 0x101 misaligned");
   endtask

   task automatic test_timeout;
      int cycles;
      set_ex(4'd3, 32'h104, 32'd0, 5'd7, 1'b1, 32'h99);
      tick();
      cycles = 0;
      while (dmReq === 1'b1 && cycles < 400) begin
         if (busErr !== 1'b0) begin total++; bad++; $display("FAIL timeout_early got=1 want=0 at %0d", cycles); end
         cycles++;
         tick();
      end
      total++; if (cycles != 255) begin bad++; $display("FAIL timeout_cycles got=%0d want=255", cycles); end
      total++; if (busErr !== 1'b1) begin bad++; $display("FAIL timeout_buserr got=%b want=1", busErr); end
      total++; if ({stallReq, MemWriteData} !== {1'b0, 32'd0}) begin bad++; $display("FAIL timeout_done got=%b/%h want=0/0", stallReq, MemWriteData); end
      stall = 6'b010000;
      tick();
      total++; if ({busErr, dmReq, stallReq, MemWriteData} !== {3'b000, 32'd0}) begin bad++; $display("FAIL timeout_hold got=%b/%h want=000/0", {busErr, dmReq, stallReq}, MemWriteData); end
      stall = 6'd0;
      set_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      tick();
      $display("txn LW timeout after %0d busy cycles", cycles);
   endtask

   task automatic test_done_stall;
      set_ex(4'd4, 32'h10D, 32'd0, 5'd12, 1'b1, 32'd0);
      tick();
      dmAck = 1'b1; dmRdata = 32'hAABB_CCDD; stall = 6'b010000;
      tick();
      dmAck = 1'b0;
      set_ex(4'd3, 32'h120, 32'd0, 5'd1, 1'b1, 32'd0);
      for (int i = 0; i < 3; i++) begin
         total++; if ({stallReq, dmReq, MemWriteData} !== {2'b00, 32'h0000_00CC}) begin bad++; $display("FAIL done_hold%0d got=%b/%h want=00/000000cc", i, {stallReq, dmReq}, MemWriteData); end
         tick();
      end
      stall = 6'd0;
      tick();
      total++; if (stallReq !== 1'b1) begin bad++; $display("FAIL done_release got=%b want=1", stallReq); end
      set_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      tick();
      $display("txn LBU 0x10D held in DONE 3 cycles");
   endtask

   task automatic test_reset_mid_busy;
      set_ex(4'd3, 32'h108, 32'd0, 5'd2, 1'b1, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      total++; if ({dmReq, stallReq, MemWriteReg} !== 3'b000) begin bad++; $display("FAIL rstbusy_drop got=%b want=000", {dmReq, stallReq, MemWriteReg}); end
      set_ex(4'd0, 32'd0, 32'd0, 5'd8, 1'b0, 32'hCAFE_F00D);
      tick();
      rst = 1'b0; dmAck = 1'b1; dmRdata = 32'h1111_2222;
      #1;
      total++; if ({dmReq, MemWriteReg, MemWriteData} !== {2'b00, 32'hCAFE_F00D}) begin bad++; $display("FAIL rstbusy_idle got=%b/%h want=00/cafef00d", {dmReq, MemWriteReg}, MemWriteData); end
      tick();
      dmAck = 1'b0;
      total++; if ({dmReq, stallReq, MemWriteReg, MemWriteData} !== {3'b000, 32'hCAFE_F00D}) begin bad++; $display("FAIL rstbusy_ack got=%b/%h want=000/cafef00d", {dmReq, stallReq, MemWriteReg}, MemWriteData); end
      tick();
      $display("txn reset during BUSY, late ack ignored");
   endtask

   // Random op stream; the bench plays memory and keeps the model image
   task automatic test_random;
      for (int t = 0; t < 80; t++) begin
         int op, lat, idx;
         logic [31:0] addr, sdata, wdata, word, exp;
         logic [4:0] num;
         logic wreg;
         op    = $urandom_range(0, 15);
         addr  = 32'h100 + $urandom_range(0, 63);
         sdata = $urandom;
         wdata = $urandom;
         num   = 5'($urandom);
         wreg  = 1'($urandom);
         lat   = $urandom_range(0, 3);
         idx   = (addr / 4) % 16;
         set_ex(4'(op), addr, sdata, num, wreg, wdata);
         #1;
         if (op == 0 || op > 8) begin
            total++; if ({stallReq, MemWriteReg, MemWriteNum, MemWriteData} !== {1'b0, wreg, num, wdata}) begin bad++; $display("FAIL rnd_none%0d got=%b/%b/%0d/%h want=0/%b/%0d/%h", t, stallReq, MemWriteReg, MemWriteNum, MemWriteData, wreg, num, wdata); end
            tick();
            $display("txn %0d NONE code=%0d", t, op);
         end else if (model_misaligned(op, addr)) begin
            total++; if ({stallReq, MemWriteReg} !== 2'b00) begin bad++; $display("FAIL rnd_mis_comb%0d got=%b want=00", t, {stallReq, MemWriteReg}); end
            tick();
            total++; if ({misalign, dmReq} !== 2'b10) begin bad++; $display("FAIL rnd_mis%0d got=%b want=10", t, {misalign, dmReq}); end
            $display("txn %0d op=%0d addr=%h misaligned", t, op, addr);
         end else begin
            total++; if (stallReq !== 1'b1) begin bad++; $display("FAIL rnd_stall%0d got=%b want=1", t, stallReq); end
            tick();
            for (int c = 0; c < lat; c++) begin
               total++; if ({dmReq, stallReq} !== 2'b11) begin bad++; $display("FAIL rnd_wait%0d got=%b want=11", t, {dmReq, stallReq}); end
               tick();
            end
            total++; if ({dmReq, dmWe, dmAddr} !== {1'b1, (op >= 6) ? 1'b1 : 1'b0, addr & 32'hFFFF_FFFC}) begin bad++; $display("FAIL rnd_req%0d got=%b/%b/%h want=1/%b/%h", t, dmReq, dmWe, dmAddr, op >= 6, addr & 32'hFFFF_FFFC); end
            word = mem[idx];
            exp = 32'd0;
            if (op >= 6) begin
               total++; if ({dmBe, dmWdata} !== {model_be(op, addr), model_wdata(op, sdata)}) begin bad++; $display("FAIL rnd_store%0d got=%b/%h want=%b/%h", t, dmBe, dmWdata, model_be(op, addr), model_wdata(op, sdata)); end
               for (int b = 0; b < 4; b++)
                  if (model_be(op, addr) & (4'd1 << b)) mem[idx][8*b +: 8] = model_wdata(op, sdata) >> (8 * b);
               dmRdata = $urandom;
            end else begin
               exp = model_load(op, addr, word);
               dmRdata = word;
            end
            dmAck = 1'b1;
            tick();
            dmAck = 1'b0; dmRdata = $urandom;
            total++; if ({dmReq, stallReq, MemWriteReg, MemWriteNum} !== {2'b00, (op < 6) ? wreg : 1'b0, num}) begin bad++; $display("FAIL rnd_done%0d got=%b/%b/%0d want=00/%b/%0d", t, {dmReq, stallReq}, MemWriteReg, MemWriteNum, (op < 6) ? wreg : 1'b0, num); end
            if (op < 6) begin
               total++; if (MemWriteData !== exp) begin bad++; $display("FAIL rnd_load%0d got=%h want=%h", t, MemWriteData, exp); end
            end
            tick();
            $display("txn %0d op=%0d addr=%h lat=%0d result=%h", t, op, addr, lat, exp);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      test_reset();
      test_none_pass();
      test_lb_example();
      test_sh_example();
      test_misalign();
      test_done_stall();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
